// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer that drives NextPC of the external PC register.
// Optional interrupt entry/return support is compiled in with `define PCSEQ_IRQ_EN.
module pc_sequencer #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] IRQ_VEC   = PC_W'(8'hF0)
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [PC_W-1:0] CurrentPC,
  output logic [PC_W-1:0] NextPC,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            instr_valid,
  input  logic            dec_halt,
  input  logic            dec_jump,
  input  logic            dec_branch,
  input  logic            dec_reti,
  input  logic [PC_W-1:0] target,
  input  logic            branch_cond,
  input  logic            ex_done,
  input  logic            stall,
  input  logic            irq,
  output logic            irq_ack,
  output logic [PC_W-1:0] epc,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t          cur_state, next_state;
  logic            lat_jump, lat_branch;
  logic [PC_W-1:0] lat_target;
  logic [PC_W-1:0] resolved;

`ifdef PCSEQ_IRQ_EN
  logic            lat_reti;
  logic            mask;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            irq_take, mask_clr;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cur_state  <= BOOT;
      lat_jump   <= 1'b0;
      lat_branch <= 1'b0;
      lat_target <= '0;
`ifdef PCSEQ_IRQ_EN
      lat_reti   <= 1'b0;
`endif
    end else begin
      cur_state <= next_state;
      // Decoder outputs are only guaranteed valid during the unstalled DECODE cycle
      if (cur_state == DECODE && !stall) begin
        lat_jump   <= dec_jump;
        lat_branch <= dec_branch;
        lat_target <= target;
`ifdef PCSEQ_IRQ_EN
        lat_reti   <= dec_reti;
`endif
      end
    end
  end

  always_comb begin
    next_state = cur_state;
    NextPC     = CurrentPC;
    resolved   = CurrentPC + PC_W'(1);
    if (lat_jump || (lat_branch && branch_cond))
      resolved = lat_target;
`ifdef PCSEQ_IRQ_EN
    irq_take = 1'b0;
    mask_clr = 1'b0;
    epc_d    = epc_q;
`endif
    if (!Reset && !stall) begin
      case (cur_state)
        BOOT: begin
          NextPC     = RESET_VEC;
          next_state = FETCH;
        end
        FETCH: begin
          if (imem_ack)
            next_state = DECODE;
        end
        DECODE: begin
          next_state = dec_halt ? HALT : EXEC;
        end
        EXEC: begin
          if (ex_done) begin
            next_state = FETCH;
            NextPC     = resolved;
`ifdef PCSEQ_IRQ_EN
            // Return takes precedence and blocks a new interrupt in the same cycle
            if (lat_reti) begin
              NextPC   = epc_q;
              mask_clr = 1'b1;
            end else if (irq && !mask) begin
              NextPC   = IRQ_VEC;
              irq_take = 1'b1;
              epc_d    = resolved;
            end
`endif
          end
        end
        HALT: begin
`ifdef PCSEQ_IRQ_EN
          if (irq && !mask) begin
            NextPC     = IRQ_VEC;
            irq_take   = 1'b1;
            epc_d      = CurrentPC + PC_W'(1);
            next_state = FETCH;
          end
`endif
        end
        default: next_state = BOOT;
      endcase
    end
  end

  assign imem_req    = (cur_state == FETCH);
  assign instr_valid = (cur_state == DECODE) && !stall;
  assign state       = cur_state;

`ifdef PCSEQ_IRQ_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      epc_q <= '0;
      mask  <= 1'b0;
    end else if (irq_take) begin
      epc_q <= epc_d;
      mask  <= 1'b1;
    end else if (mask_clr) begin
      mask  <= 1'b0;
    end
  end

  assign epc     = epc_q;
  assign irq_ack = irq_take;
`else
  logic unused_irq;
  assign unused_irq = ^{irq, dec_reti, IRQ_VEC};
  assign epc        = '0;
  assign irq_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: models the PC register, memory and executor
// around the DUT; expected decode PCs are queued and checked on each instr_valid.
module tb_pc_sequencer;
  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] CurrentPC;
  logic [7:0] NextPC;
  logic [7:0] target = '0;
  logic [7:0] epc;
  logic       imem_req, instr_valid, irq_ack;
  logic       imem_ack = 1'b0;
  logic       dec_halt = 1'b0, dec_jump = 1'b0, dec_branch = 1'b0, dec_reti = 1'b0;
  logic       branch_cond = 1'b0, ex_done = 1'b0, stall = 1'b0, irq = 1'b0;
  logic [2:0] state;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_pc;

  pc_sequencer dut (
    .CLK(CLK), .Reset(Reset), .CurrentPC(CurrentPC), .NextPC(NextPC),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr_valid(instr_valid),
    .dec_halt(dec_halt), .dec_jump(dec_jump), .dec_branch(dec_branch),
    .dec_reti(dec_reti), .target(target), .branch_cond(branch_cond),
    .ex_done(ex_done), .stall(stall), .irq(irq), .irq_ack(irq_ack),
    .epc(epc), .state(state)
  );

  always #5 CLK = ~CLK;

  // External PC register
  always @(posedge CLK or posedge Reset) begin
    if (Reset) CurrentPC <= '0;
    else       CurrentPC <= NextPC;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!Reset && instr_valid) begin
      if (sb.size() == 0) check("fetch_pc_unexpected", int'(CurrentPC), -1);
      else begin
        exp_pc = sb.pop_front();
        check("fetch_pc", int'(CurrentPC), int'(exp_pc));
      end
    end
  end

  task automatic wait_fetch();
    int n = 0;
    while (state != 3'd1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("fetch_wait_state", int'(state), 1);
  endtask

  // One instruction: fetch with ack delay, decode flags, exec exit with optional stall
  task automatic run_instr(input int ack_dly, input logic jmp, input logic br,
                           input logic cond, input logic reti, input logic [7:0] tgt,
                           input logic irq_v, input int stall_n, input logic [7:0] exp_next,
                           input logic exp_ack, input logic [7:0] exp_epc);
    wait_fetch();
    repeat (ack_dly) begin
      check("imem_req_hold", int'(imem_req), 1);
      @(negedge CLK);
    end
    imem_ack = 1'b1; dec_jump = jmp; dec_branch = br; dec_reti = reti; target = tgt;
    @(negedge CLK);
    imem_ack = 1'b0;
    @(negedge CLK);
    dec_jump = 1'b0; dec_branch = 1'b0; dec_reti = 1'b0; target = '0;
    ex_done = 1'b1; branch_cond = cond; irq = irq_v; stall = (stall_n > 0);
    repeat (stall_n) begin
      #1;
      check("stall_next_pc", int'(NextPC), int'(CurrentPC));
      check("stall_state", int'(state), 3);
      @(negedge CLK);
    end
    stall = 1'b0;
    #1;
    check("exit_next_pc", int'(NextPC), int'(exp_next));
    check("exit_irq_ack", int'(irq_ack), int'(exp_ack));
    @(negedge CLK);
    ex_done = 1'b0; branch_cond = 1'b0; irq = 1'b0;
    check("epc", int'(epc), int'(exp_epc));
    sb.push_back(exp_next);
  endtask

  task automatic run_halt(input logic [7:0] hpc, input int cycles);
    wait_fetch();
    check("imem_req_halt_fetch", int'(imem_req), 1);
    imem_ack = 1'b1; dec_halt = 1'b1;
    @(negedge CLK);
    imem_ack = 1'b0;
    @(negedge CLK);
    dec_halt = 1'b0;
    check("halt_state", int'(state), 4);
    repeat (cycles) begin
      check("halt_next_pc", int'(NextPC), int'(hpc));
      check("halt_imem_req", int'(imem_req), 0);
      @(negedge CLK);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_state", int'(state), 0);
    check("rst_imem_req", int'(imem_req), 0);
    check("rst_instr_valid", int'(instr_valid), 0);
    check("rst_irq_ack", int'(irq_ack), 0);
    check("rst_epc", int'(epc), 0);
    check("rst_next_pc", int'(NextPC), int'(CurrentPC));
    Reset = 1'b0;
    #1;
    check("boot_next_pc", int'(NextPC), 'h00);
    sb.push_back(8'h00);

    for (int i = 0; i < 5; i++)
      run_instr(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'(i + 1), 0, 8'h00);
    run_instr(1, 1, 0, 0, 0, 8'h20, 0, 0, 8'h20, 0, 8'h00);  // jump at 05
    run_instr(1, 0, 1, 0, 0, 8'h30, 0, 0, 8'h21, 0, 8'h00);  // branch not taken
    run_instr(1, 0, 1, 1, 0, 8'h40, 0, 0, 8'h40, 0, 8'h00);  // branch taken
    run_instr(3, 0, 0, 0, 0, 8'h00, 0, 2, 8'h41, 0, 8'h00);  // slow ack + stall
    run_instr(1, 1, 0, 0, 0, 8'hFE, 0, 0, 8'hFE, 0, 8'h00);
    run_instr(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 8'h00);
    run_instr(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);  // wrap FF -> 00
    run_instr(1, 1, 0, 0, 0, 8'h07, 0, 0, 8'h07, 0, 8'h00);
`ifdef PCSEQ_IRQ_EN
    run_instr(1, 0, 0, 0, 0, 8'h00, 1, 0, 8'hF0, 1, 8'h08);  // irq taken at 07
    run_instr(1, 0, 0, 0, 0, 8'h00, 1, 0, 8'hF1, 0, 8'h08);  // masked
    run_instr(1, 0, 0, 0, 1, 8'h30, 1, 0, 8'h08, 0, 8'h08);  // reti
    run_instr(1, 1, 0, 0, 0, 8'h10, 0, 0, 8'h10, 0, 8'h08);
    run_halt(8'h10, 20);
    irq = 1'b1;
    #1;
    check("halt_irq_ack", int'(irq_ack), 1);
    check("halt_irq_next_pc", int'(NextPC), 'hF0);
    @(negedge CLK);
    irq = 1'b0;
    check("halt_irq_epc", int'(epc), 'h11);
    check("halt_irq_state", int'(state), 1);
`else
    run_instr(1, 0, 0, 0, 0, 8'h00, 1, 0, 8'h08, 0, 8'h00);  // irq ignored
    run_instr(1, 0, 0, 0, 1, 8'h30, 1, 0, 8'h09, 0, 8'h00);  // reti is sequential
    run_instr(1, 1, 0, 0, 0, 8'h10, 0, 0, 8'h10, 0, 8'h00);
    run_halt(8'h10, 20);
    Reset = 1'b1;
    @(negedge CLK);
    check("halt_reset_state", int'(state), 0);
    Reset = 1'b0;
    wait_fetch();
`endif
    // Reset in the middle of a fetch cycle
    #2 Reset = 1'b1;
    #1;
    check("async_imem_req", int'(imem_req), 0);
    check("async_state", int'(state), 0);
    check("async_pc", int'(CurrentPC), 0);
    @(negedge CLK);
    Reset = 1'b0;
    sb.push_back(8'h00);
    run_instr(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h01, 0, 8'h00);
    run_halt(8'h01, 4);
    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
